// File: rtl/uart_wb_pkg.sv
// Shared constants and FSM encoding for the UART Wishbone initiator.
// UART register offsets and status bit positions live here.
package uart_wb_pkg;

    localparam logic [7:0] UART_REG_DATA   = 8'h00;
    localparam logic [7:0] UART_REG_STATUS = 8'h05;

    localparam int STATUS_TX_IDLE_BIT  = 5;
    localparam int STATUS_RX_READY_BIT = 0;

    typedef enum logic [2:0] {
        S_IDLE,
        S_STAT,
        S_DECIDE,
        S_WR,
        S_RD,
        S_GAP
    } state_t;

endpackage

// File: rtl/uart_wb_if.sv
// Wishbone classic bus bundle between the UART initiator and the bus.
// Signal names keep the initiator's point of view (_o driven by master).
interface uart_wb_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                    wb_cyc_o;
    logic                    wb_stb_o;
    logic                    wb_ack_i;
    logic [ADDR_WIDTH-1:0]   wb_adr_o;
    logic [DATA_WIDTH-1:0]   wb_dat_o;
    logic [DATA_WIDTH-1:0]   wb_dat_i;
    logic [DATA_WIDTH/8-1:0] wb_sel_o;
    logic                    wb_we_o;

    modport master (
        output wb_cyc_o, wb_stb_o, wb_adr_o, wb_dat_o, wb_sel_o, wb_we_o,
        input  wb_ack_i, wb_dat_i
    );

    modport slave (
        input  wb_cyc_o, wb_stb_o, wb_adr_o, wb_dat_o, wb_sel_o, wb_we_o,
        output wb_ack_i, wb_dat_i
    );
endinterface

// File: rtl/uart_wb_master_xfer.sv
// Single Wishbone transfer engine: holds the request until ack or timeout.
// done/timeout are combinational so the caller reacts on the ack edge.
module wb_single_xfer #(
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int ACK_TIMEOUT = 255
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  i_req,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    input  logic                  i_we,
    input  logic [DATA_WIDTH-1:0] i_wdata,
    output logic                  o_done,
    output logic                  o_timeout,
    output logic [7:0]            o_rdata,
    uart_wb_if.master             wb
);
    localparam int SW = DATA_WIDTH / 8;
    localparam logic [15:0] TMO_LAST = 16'(ACK_TIMEOUT - 1);

    logic                  r_stb;
    logic                  r_we;
    logic [ADDR_WIDTH-1:0] r_adr;
    logic [DATA_WIDTH-1:0] r_dat;
    logic [SW-1:0]         r_sel;
    logic [15:0]           r_cnt;
    logic                  w_unused;

    assign o_done    = r_stb && wb.wb_ack_i;
    assign o_timeout = (ACK_TIMEOUT != 0) && r_stb && !wb.wb_ack_i
                       && (r_cnt == TMO_LAST);
    assign o_rdata   = wb.wb_dat_i[7:0];
    assign w_unused  = ^wb.wb_dat_i[DATA_WIDTH-1:8];

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_stb <= 1'b0;
            r_we  <= 1'b0;
            r_adr <= '0;
            r_dat <= '0;
            r_sel <= '0;
            r_cnt <= '0;
        end else if (o_done || o_timeout) begin
            r_stb <= 1'b0;
            r_we  <= 1'b0;
            r_adr <= '0;
            r_dat <= '0;
            r_sel <= '0;
            r_cnt <= '0;
        end else if (i_req && !r_stb) begin
            r_stb <= 1'b1;
            r_we  <= i_we;
            r_adr <= i_addr;
            r_dat <= i_wdata;
            r_sel <= SW'(1);
            r_cnt <= '0;
        end else if (r_stb) begin
            r_cnt <= r_cnt + 16'd1;
        end
    end

    assign wb.wb_cyc_o = r_stb;
    assign wb.wb_stb_o = r_stb;
    assign wb.wb_we_o  = r_we;
    assign wb.wb_adr_o = r_adr;
    assign wb.wb_dat_o = r_dat;
    assign wb.wb_sel_o = r_sel;
endmodule

// File: rtl/uart_wb_master.sv
// Polls the UART status register and moves bytes between the client
// valid/ready channels and the UART data register over Wishbone.
module uart_wb_master
    import uart_wb_pkg::*;
#(
    parameter int                    ADDR_WIDTH  = 32,
    parameter int                    DATA_WIDTH  = 32,
    parameter logic [ADDR_WIDTH-1:0] UART_BASE   = 32'h1000_0000,
    parameter int                    POLL_GAP    = 4,
    parameter int                    ACK_TIMEOUT = 255
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    uart_wb_if.master  wb,
    input  logic       tx_valid_i,
    output logic       tx_ready_o,
    input  logic [7:0] tx_data_i,
    output logic       rx_valid_o,
    input  logic       rx_ready_i,
    output logic [7:0] rx_data_o,
    output logic       err_o
);
    localparam logic [ADDR_WIDTH-1:0] ADR_DATA =
        UART_BASE + ADDR_WIDTH'(UART_REG_DATA);
    localparam logic [ADDR_WIDTH-1:0] ADR_STAT =
        UART_BASE + ADDR_WIDTH'(UART_REG_STATUS);

    state_t                r_state, w_state_nxt;
    logic                  r_tx_full, r_rx_full;
    logic [7:0]            r_tx_data, r_rx_data;
    logic                  r_st_tx, r_st_rx;
    logic [7:0]            r_gap;
    logic                  r_err;
    logic                  w_req, w_we, w_done, w_tmo;
    logic [ADDR_WIDTH-1:0] w_addr;
    logic [DATA_WIDTH-1:0] w_wdata;
    logic [7:0]            w_rdata;
    logic                  w_tx_hs, w_rx_hs;

    assign tx_ready_o = !r_tx_full;
    assign rx_valid_o = r_rx_full;
    assign rx_data_o  = r_rx_data;
    assign err_o      = r_err;
    assign w_tx_hs    = tx_valid_i && !r_tx_full;
    assign w_rx_hs    = rx_ready_i && r_rx_full;

    wb_single_xfer #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH),
        .ACK_TIMEOUT(ACK_TIMEOUT)
    ) u_xfer (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .i_req    (w_req),
        .i_addr   (w_addr),
        .i_we     (w_we),
        .i_wdata  (w_wdata),
        .o_done   (w_done),
        .o_timeout(w_tmo),
        .o_rdata  (w_rdata),
        .wb       (wb)
    );

    always_ff @(posedge clk_i) begin
        if (!rst_ni) r_state <= S_IDLE;
        else         r_state <= w_state_nxt;
    end

    // RX is served before TX when both are possible
    always_comb begin
        w_state_nxt = r_state;
        w_req       = 1'b0;
        w_we        = 1'b0;
        w_addr      = '0;
        w_wdata     = '0;
        unique case (r_state)
            S_IDLE: begin
                if (r_tx_full || !r_rx_full) begin
                    w_state_nxt = S_STAT;
                    w_req       = 1'b1;
                    w_addr      = ADR_STAT;
                end
            end
            S_STAT: begin
                if (w_done)     w_state_nxt = S_DECIDE;
                else if (w_tmo) w_state_nxt = S_GAP;
            end
            S_DECIDE: begin
                if (r_st_rx && !r_rx_full) begin
                    w_state_nxt = S_RD;
                    w_req       = 1'b1;
                    w_addr      = ADR_DATA;
                end else if (r_st_tx && r_tx_full) begin
                    w_state_nxt = S_WR;
                    w_req       = 1'b1;
                    w_we        = 1'b1;
                    w_addr      = ADR_DATA;
                    w_wdata     = DATA_WIDTH'(r_tx_data);
                end else begin
                    w_state_nxt = S_GAP;
                end
            end
            S_WR, S_RD: begin
                if (w_done || w_tmo) w_state_nxt = S_GAP;
            end
            S_GAP: begin
                if (r_gap == 8'(POLL_GAP - 1)) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_tx_full <= 1'b0;
            r_tx_data <= '0;
            r_rx_full <= 1'b0;
            r_rx_data <= '0;
            r_st_tx   <= 1'b0;
            r_st_rx   <= 1'b0;
            r_gap     <= '0;
            r_err     <= 1'b0;
        end else begin
            r_err <= w_tmo;
            r_gap <= (r_state == S_GAP) ? r_gap + 8'd1 : 8'd0;
            if (w_tx_hs) begin
                r_tx_full <= 1'b1;
                r_tx_data <= tx_data_i;
            end else if (r_state == S_WR && w_done) begin
                r_tx_full <= 1'b0;
            end
            if (r_state == S_STAT && w_done) begin
                r_st_tx <= w_rdata[STATUS_TX_IDLE_BIT];
                r_st_rx <= w_rdata[STATUS_RX_READY_BIT];
            end
            if (r_state == S_RD && w_done) begin
                r_rx_full <= 1'b1;
                r_rx_data <= w_rdata;
            end else if (w_rx_hs) begin
                r_rx_full <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_uart_wb_master.sv
// Directed bench: UART register model on the bus, byte client on the channels.
module tb_uart_wb_master;
    localparam logic [31:0] BASE   = 32'h1000_0000;
    localparam logic [31:0] A_DATA = 32'h1000_0000;
    localparam logic [31:0] A_STAT = 32'h1000_0005;
    localparam int          GAP    = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       tx_valid, tx_ready, rx_valid, rx_ready, err;
    logic [7:0] tx_data, rx_data;

    uart_wb_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) wb ();

    uart_wb_master #(
        .ADDR_WIDTH (32),
        .DATA_WIDTH (32),
        .UART_BASE  (BASE),
        .POLL_GAP   (GAP),
        .ACK_TIMEOUT(8)
    ) dut (
        .clk_i     (clk),
        .rst_ni    (rst_n),
        .wb        (wb),
        .tx_valid_i(tx_valid),
        .tx_ready_o(tx_ready),
        .tx_data_i (tx_data),
        .rx_valid_o(rx_valid),
        .rx_ready_i(rx_ready),
        .rx_data_o (rx_data),
        .err_o     (err)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    // slave model controls (written only by the stimulus block)
    logic       ack_en     = 1'b1;
    logic       tx_idle    = 1'b0;
    logic [7:0] rx_byte    = 8'h00;
    int         rx_target  = 0;
    int         zero_until = 0;

    // bus log (written only by the logger)
    int          n_stat = 0, n_rd = 0, n_wr = 0, n_errp = 0;
    int          cyc_cnt = 0, rd_cyc = 0, wr_cyc = 0;
    int          idle_run = 0, min_gap = 255;
    logic        prev_stb = 1'b0;
    logic [31:0] last_wdat = '0, last_wadr = '0;
    logic [3:0]  last_wsel = '0;

    // ack lands in the same cycle stb is first seen
    always @(negedge clk) begin
        wb.wb_ack_i = ack_en && wb.wb_cyc_o && wb.wb_stb_o;
        if (wb.wb_adr_o == A_STAT) begin
            if (n_stat < zero_until) wb.wb_dat_i = 32'h0;
            else wb.wb_dat_i = {26'h0, tx_idle, 4'h0, (n_rd < rx_target)};
        end else begin
            wb.wb_dat_i = {24'h0, rx_byte};
        end
    end

    always @(posedge clk) begin
        cyc_cnt++;
        if (err) n_errp++;
        if (!wb.wb_stb_o) begin
            idle_run++;
        end else begin
            if (!prev_stb && wb.wb_adr_o == A_STAT && n_stat > 0
                && idle_run < min_gap)
                min_gap = idle_run;
            idle_run = 0;
        end
        prev_stb = wb.wb_stb_o;
        if (rst_n && wb.wb_stb_o && wb.wb_ack_i) begin
            if (wb.wb_we_o) begin
                n_wr++;
                wr_cyc    = cyc_cnt;
                last_wdat = wb.wb_dat_o;
                last_wadr = wb.wb_adr_o;
                last_wsel = wb.wb_sel_o;
            end else if (wb.wb_adr_o == A_STAT) begin
                n_stat++;
            end else begin
                n_rd++;
                rd_cyc = cyc_cnt;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input logic [7:0] b);
        logic ok = 1'b0;
        for (int i = 0; i < 200 && !ok; i++) begin
            if (tx_ready) ok = 1'b1;
            else tick();
        end
        chk("send_ready", {31'h0, ok}, 32'h1);
        tx_valid = 1'b1;
        tx_data  = b;
        tick();
        tx_valid = 1'b0;
    endtask

    task automatic wait_wr(input int target, input string tag);
        logic ok = 1'b0;
        for (int i = 0; i < 400 && !ok; i++) begin
            if (n_wr >= target) ok = 1'b1;
            else tick();
        end
        chk(tag, {31'h0, ok}, 32'h1);
    endtask

    int          s0, w0, r0, e0, n;
    logic        ok;

    initial begin
        rst_n = 1'b0; tx_valid = 1'b0; tx_data = 8'h00; rx_ready = 1'b0;
        tick(3);
        chk("rst_stb", {31'h0, wb.wb_stb_o}, 32'h0);
        chk("rst_cyc", {31'h0, wb.wb_cyc_o}, 32'h0);
        chk("rst_adr", wb.wb_adr_o, 32'h0);
        chk("rst_dat", wb.wb_dat_o, 32'h0);
        chk("rst_sel", {28'h0, wb.wb_sel_o}, 32'h0);
        chk("rst_we", {31'h0, wb.wb_we_o}, 32'h0);
        chk("rst_txr", {31'h0, tx_ready}, 32'h1);
        chk("rst_rxv", {31'h0, rx_valid}, 32'h0);
        chk("rst_rxd", {24'h0, rx_data}, 32'h0);
        chk("rst_err", {31'h0, err}, 32'h0);
        rst_n = 1'b1;

        // RX byte 0x96, client holds rx_ready low
        rx_byte = 8'h96; rx_target = 1;
        ok = 1'b0;
        for (int i = 0; i < 200 && !ok; i++) begin
            if (rx_valid) ok = 1'b1;
            else tick();
        end
        chk("rx_valid_rise", {31'h0, ok}, 32'h1);
        chk("rx_data_96", {24'h0, rx_data}, 32'h96);
        tick(10);
        s0 = n_stat;
        tick(20);
        chk("rx_full_no_poll", n_stat - s0, 0);
        chk("rx_one_read", n_rd, 1);

        // best-case TX of 0x55, status 0x20
        tx_idle = 1'b1; w0 = n_wr;
        tx_valid = 1'b1; tx_data = 8'h55;
        chk("t0_ready", {31'h0, tx_ready}, 32'h1);
        tick();
        tx_valid = 1'b0;
        chk("t0_full", {31'h0, tx_ready}, 32'h0);
        tick();
        chk("t1_stb", {31'h0, wb.wb_stb_o}, 32'h1);
        chk("t1_adr", wb.wb_adr_o, A_STAT);
        chk("t1_we", {31'h0, wb.wb_we_o}, 32'h0);
        tick();
        chk("t2_stb", {31'h0, wb.wb_stb_o}, 32'h0);
        tick();
        chk("t3_stb", {31'h0, wb.wb_stb_o}, 32'h1);
        chk("t3_we", {31'h0, wb.wb_we_o}, 32'h1);
        chk("t3_adr", wb.wb_adr_o, A_DATA);
        chk("t3_dat", wb.wb_dat_o, 32'h55);
        chk("t3_sel", {28'h0, wb.wb_sel_o}, 32'h1);
        chk("t3_txr", {31'h0, tx_ready}, 32'h0);
        tick();
        chk("t5_stb", {31'h0, wb.wb_stb_o}, 32'h0);
        chk("t5_txr", {31'h0, tx_ready}, 32'h1);
        chk("t5_nwr", n_wr - w0, 1);
        tick(10);

        // three busy polls before TX idle
        s0 = n_stat; w0 = n_wr; zero_until = n_stat + 3;
        send(8'hC3);
        wait_wr(w0 + 1, "poll_wr_seen");
        tick(10);
        chk("poll_nstat", n_stat - s0, 4);
        chk("poll_nwr", n_wr - w0, 1);
        chk("poll_dat", last_wdat, 32'hC3);
        chk("poll_adr", last_wadr, A_DATA);
        chk("poll_sel", {28'h0, last_wsel}, 32'h1);
        chk("poll_gap_ok", {31'h0, min_gap >= GAP}, 32'h1);

        // status 0x21 with TX and RX pending: read first, then write
        tx_idle = 1'b0; rx_byte = 8'h3C; rx_target = n_rd + 1;
        send(8'hA5);
        tick(20);
        w0 = n_wr; r0 = n_rd;
        rx_ready = 1'b1; tx_idle = 1'b1;
        tick();
        rx_ready = 1'b0;
        chk("both_rx_drained", {31'h0, rx_valid}, 32'h0);
        wait_wr(w0 + 1, "both_wr_seen");
        chk("both_nrd", n_rd - r0, 1);
        chk("both_order", {31'h0, rd_cyc < wr_cyc}, 32'h1);
        chk("both_rxv", {31'h0, rx_valid}, 32'h1);
        chk("both_rxd", {24'h0, rx_data}, 32'h3C);
        chk("both_wdat", last_wdat, 32'hA5);

        // RX full blocks further reads even with status bit0 set
        rx_target = n_rd + 1; r0 = n_rd; w0 = n_wr;
        send(8'h11);
        wait_wr(w0 + 1, "blk_wr_seen");
        tick(20);
        chk("blk_nrd", n_rd - r0, 0);
        chk("blk_wdat", last_wdat, 32'h11);
        chk("blk_rxd", {24'h0, rx_data}, 32'h3C);

        // ack timeout of 8 cycles, then retry
        ack_en = 1'b0; e0 = n_errp; w0 = n_wr;
        send(8'h77);
        ok = 1'b0;
        for (int i = 0; i < 60 && !ok; i++) begin
            if (wb.wb_stb_o) ok = 1'b1;
            else tick();
        end
        chk("tmo_stb_rise", {31'h0, ok}, 32'h1);
        n = 1;
        for (int i = 0; i < 20 && wb.wb_stb_o; i++) begin
            tick();
            if (wb.wb_stb_o) n++;
        end
        chk("tmo_len", n, 8);
        chk("tmo_err_hi", {31'h0, err}, 32'h1);
        ack_en = 1'b1;
        tick();
        chk("tmo_err_lo", {31'h0, err}, 32'h0);
        chk("tmo_queued", {31'h0, tx_ready}, 32'h0);
        wait_wr(w0 + 1, "tmo_retry");
        chk("tmo_retry_dat", last_wdat, 32'h77);
        chk("tmo_err_once", n_errp - e0, 1);

        // reset during a data write
        w0 = n_wr;
        send(8'h99);
        ok = 1'b0;
        for (int i = 0; i < 200 && !ok; i++) begin
            if (wb.wb_stb_o && wb.wb_we_o) ok = 1'b1;
            else tick();
        end
        chk("rstwr_seen", {31'h0, ok}, 32'h1);
        ack_en = 1'b0; rst_n = 1'b0;
        tick();
        chk("rstwr_stb", {31'h0, wb.wb_stb_o}, 32'h0);
        chk("rstwr_cyc", {31'h0, wb.wb_cyc_o}, 32'h0);
        chk("rstwr_we", {31'h0, wb.wb_we_o}, 32'h0);
        chk("rstwr_adr", wb.wb_adr_o, 32'h0);
        chk("rstwr_dat", wb.wb_dat_o, 32'h0);
        chk("rstwr_sel", {28'h0, wb.wb_sel_o}, 32'h0);
        chk("rstwr_txr", {31'h0, tx_ready}, 32'h1);
        chk("rstwr_rxv", {31'h0, rx_valid}, 32'h0);
        chk("rstwr_rxd", {24'h0, rx_data}, 32'h0);
        chk("rstwr_err", {31'h0, err}, 32'h0);
        chk("rstwr_nowr", n_wr - w0, 0);
        ack_en = 1'b1; rst_n = 1'b1;
        tick(5);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
